// File: rtl/wb_select_pipe.sv
// MEM/WB pipeline register with destination and writeback-data selection.
// Define WB_LOAD_EXT_EN to build the byte/halfword load extension; otherwise loads pass the word through.
module wb_select_pipe #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          reg_write,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    input  logic [1:0]    reg_dst,
    input  logic [1:0]    wb_sel,
    input  logic [2:0]    load_type,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] mem_rdata,
    input  logic [DW-1:0] pc,
    output logic          wb_valid,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [DW-1:0] wb_pc
);

    logic [AW-1:0] addr_c;
    logic          we_c;
    logic [DW-1:0] load_c;
    logic [DW-1:0] data_c;

    always_comb begin
        addr_c = rt;
        case (reg_dst)
            2'b01:   addr_c = rd;
            2'b10:   addr_c = AW'(LINK_REG);
            default: addr_c = rt;
        endcase
    end

    assign we_c = in_valid & reg_write & (addr_c != '0);

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = mem_rdata[7:0];
        case (addr_lo)
            2'd1:    byte_c = mem_rdata[15:8];
            2'd2:    byte_c = mem_rdata[23:16];
            2'd3:    byte_c = mem_rdata[31:24];
            default: byte_c = mem_rdata[7:0];
        endcase
    end

    // addr_lo[0] is deliberately ignored for halves; misalignment is trapped elsewhere
    assign half_c = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_c = mem_rdata;
        case (load_type)
            3'b001:  load_c = {{(DW-8){byte_c[7]}}, byte_c};
            3'b010:  load_c = {{(DW-8){1'b0}}, byte_c};
            3'b011:  load_c = {{(DW-16){half_c[15]}}, half_c};
            3'b100:  load_c = {{(DW-16){1'b0}}, half_c};
            default: load_c = mem_rdata;
        endcase
    end
`else
    logic unused_load_ctl;

    assign unused_load_ctl = ^{load_type, addr_lo};
    assign load_c = mem_rdata;
`endif

    always_comb begin
        data_c = '0;
        case (wb_sel)
            2'b00:   data_c = alu_result;
            2'b01:   data_c = load_c;
            2'b10:   data_c = pc + DW'(LINK_OFFSET);
            default: data_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_pc    <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_pc    <= '0;
        end else if (en) begin
            wb_valid <= in_valid;
            wb_we    <= we_c;
            wb_addr  <= addr_c;
            wb_data  <= data_c;
            wb_pc    <= pc;
        end
    end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Self-checking bench for wb_select_pipe: per-cycle model compare plus literal spot checks.
// Load expectations follow WB_LOAD_EXT_EN the same way the design build does.
module tb_wb_select_pipe;

    logic        clk = 1'b0;
    logic        reset, en, flush, in_valid, reg_write;
    logic [4:0]  rt, rd;
    logic [1:0]  reg_dst, wb_sel, addr_lo;
    logic [2:0]  load_type;
    logic [31:0] alu_result, mem_rdata, pc;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, wb_pc;

    int total = 0;
    int bad   = 0;

    wb_select_pipe dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .reg_write(reg_write), .rt(rt), .rd(rd),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .load_type(load_type),
        .addr_lo(addr_lo), .alu_result(alu_result), .mem_rdata(mem_rdata),
        .pc(pc), .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_pc(wb_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected load value from byte/half arithmetic on the read word
    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] al,
                                               input logic [31:0] mem);
        logic [31:0] b, h;
        b = (mem >> (8 * al)) & 32'hFF;
        h = (mem >> (16 * (al / 2))) & 32'hFFFF;
`ifdef WB_LOAD_EXT_EN
        case (lt)
            3'd1:    return (b >= 128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return mem;
        endcase
`else
        return mem + 32'd0 * (b + h + 32'(lt));
`endif
    endfunction

    logic        m_valid = 0, m_we = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0, m_pc = 0;

    // Model update from inputs seen at each edge, then compare shortly after
    always @(posedge clk) begin
        if (reset || flush) begin
            m_valid = 0; m_we = 0; m_addr = 0; m_data = 0; m_pc = 0;
        end else if (en) begin
            m_addr  = (reg_dst == 2'd1) ? rd : (reg_dst == 2'd2) ? 5'd31 : rt;
            m_valid = in_valid;
            m_we    = in_valid && reg_write && (m_addr != 0);
            m_pc    = pc;
            case (wb_sel)
                2'd0: m_data = alu_result;
                2'd1: m_data = model_load(load_type, addr_lo, mem_rdata);
                2'd2: m_data = pc + 32'd8;
                default: m_data = 0;
            endcase
        end
        #1;
        chk("model_valid", 32'(wb_valid), 32'(m_valid));
        chk("model_we",    32'(wb_we),    32'(m_we));
        chk("model_addr",  32'(wb_addr),  32'(m_addr));
        chk("model_data",  wb_data,       m_data);
        chk("model_pc",    wb_pc,         m_pc);
    end

    task automatic set_op(input logic v, input logic rw, input logic [1:0] dst,
                          input logic [4:0] t, input logic [4:0] d, input logic [1:0] sel,
                          input logic [2:0] lt, input logic [1:0] al, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] p);
        in_valid = v; reg_write = rw; reg_dst = dst; rt = t; rd = d; wb_sel = sel;
        load_type = lt; addr_lo = al; alu_result = alu; mem_rdata = mem; pc = p;
    endtask

    // One edge; inputs are changed only at negedges
    task automatic step();
        @(posedge clk);
        #2;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, 32'(wb_valid), 0);
        chk({name, "_we"},    32'(wb_we),    0);
        chk({name, "_addr"},  32'(wb_addr),  0);
        chk({name, "_data"},  wb_data,       0);
        chk({name, "_pc"},    wb_pc,         0);
    endtask

    task automatic load_case(input string name, input logic [2:0] lt, input logic [1:0] al,
                             input logic [31:0] exp);
        set_op(1, 1, 2'd1, 5'd0, 5'd9, 2'd1, lt, al, 32'h0, 32'h80FF7F01, 32'h100);
        step();
        chk(name, wb_data, exp);
    endtask

    initial begin
        reset = 1; en = 1; flush = 0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_zero("reset_init");

        reset = 0;
        set_op(1, 1, 2'd0, 5'd3, 5'd4, 2'd0, 0, 0, 32'hDEADBEEF, 0, 32'h44);
        step();
        chk("pre_reset_data", wb_data, 32'hDEADBEEF);

        reset = 1;
        #1;
        chk_zero("reset_async");
        step();
        reset = 0;

        set_op(1, 1, 2'd1, 5'd0, 5'd8, 2'd0, 0, 0, 32'h12345678, 0, 32'h200);
        step();
        chk("post_reset_addr", 32'(wb_addr), 8);
        chk("post_reset_data", wb_data, 32'h12345678);
        chk("post_reset_we",   32'(wb_we), 1);

        set_op(1, 1, 2'd2, 5'd1, 5'd2, 2'd2, 0, 0, 0, 0, 32'h00003000);
        step();
        chk("link_addr", 32'(wb_addr), 31);
        chk("link_data", wb_data, 32'h00003008);
        pc = 32'hFFFFFFFC;
        step();
        chk("link_wrap", wb_data, 32'h00000004);

`ifdef WB_LOAD_EXT_EN
        load_case("lb_a2",  3'd1, 2'd2, 32'hFFFFFFFF);
        load_case("lbu_a3", 3'd2, 2'd3, 32'h00000080);
        load_case("lh_a2",  3'd3, 2'd2, 32'hFFFF80FF);
        load_case("lhu_a0", 3'd4, 2'd0, 32'h00007F01);
        load_case("lh_a3",  3'd3, 2'd3, 32'hFFFF80FF);
        load_case("lb_a0",  3'd1, 2'd0, 32'h00000001);
`else
        load_case("lb_noext",  3'd1, 2'd2, 32'h80FF7F01);
        load_case("lhu_noext", 3'd4, 2'd0, 32'h80FF7F01);
`endif
        load_case("lw",       3'd0, 2'd1, 32'h80FF7F01);
        load_case("reserved", 3'd7, 2'd3, 32'h80FF7F01);

        // Sweep every load code and byte lane against the model
        for (int lt = 0; lt < 8; lt++)
            for (int al = 0; al < 4; al++) begin
                set_op(1, 1, 2'd3, 5'd7, 5'd0, 2'd1, 3'(lt), 2'(al), 0, 32'h7F80C3A5, 32'h400);
                step();
            end

        set_op(1, 1, 2'd0, 5'd0, 5'd5, 2'd0, 0, 0, 32'h55, 0, 32'h500);
        step();
        chk("r0_addr",  32'(wb_addr), 0);
        chk("r0_we",    32'(wb_we), 0);
        chk("r0_valid", 32'(wb_valid), 1);

        set_op(0, 1, 2'd1, 5'd0, 5'd6, 2'd3, 0, 0, 32'h77, 0, 32'h504);
        step();
        chk("invalid_we",   32'(wb_we), 0);
        chk("invalid_data", wb_data, 0);
        chk("invalid_pc",   wb_pc, 32'h504);

        set_op(1, 1, 2'd1, 5'd0, 5'd10, 2'd0, 0, 0, 32'hAAAA0001, 0, 32'h600);
        step();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            set_op(1, 1, 2'd1, 5'd0, 5'(11 + i), 2'd0, 0, 0, 32'hBBBB0000 + 32'(i), 0, 32'h700);
            step();
            chk("stall_data", wb_data, 32'hAAAA0001);
            chk("stall_addr", 32'(wb_addr), 10);
        end
        en = 1;
        step();
        chk("resume_data", wb_data, 32'hBBBB0002);

        en = 0; flush = 1;
        step();
        chk("flush_valid", 32'(wb_valid), 0);
        chk("flush_we",    32'(wb_we), 0);
        chk("flush_data",  wb_data, 0);
        flush = 0; en = 1;

        set_op(1, 1, 2'd2, 5'd0, 5'd0, 2'd0, 0, 0, 32'hCAFEF00D, 0, 32'h800);
        step();
        reset = 1; flush = 1;
        #1;
        chk_zero("reset_flush_async");
        step();
        chk_zero("reset_flush_edge");
        reset = 0; flush = 0;
        step();
        chk("after_rf_data", wb_data, 32'hCAFEF00D);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
